// File: rtl/esm_issue_buffer_if.sv
// Upstream accept and downstream issue handshakes of the ESM issue buffer.
// The DUT connects through the slave modport and the producer/consumer side through master.
interface esm_issue_buffer_if #(
   parameter int unsigned Instruction_word_size = 32,
   parameter int unsigned bs                    = 16
);
   logic                             in_valid;
   logic                             in_ready;
   logic [Instruction_word_size-1:0] Instr_in;
   logic                             out_valid;
   logic                             out_ready;
   logic [Instruction_word_size-1:0] out_instr;
   logic [$clog2(bs)-1:0]            out_slot;

   modport master (
      output in_valid, Instr_in, out_ready,
      input  in_ready, out_valid, out_instr, out_slot
   );

   modport slave (
      input  in_valid, Instr_in, out_ready,
      output in_ready, out_valid, out_instr, out_slot
   );
endinterface

// File: rtl/esm_issue_buffer.sv
// Instruction buffer with lowest-free-slot allocation and round-robin issue of
// instructions the dependency core reports as independent.
module esm_issue_buffer #(
   parameter int unsigned Instruction_word_size = 32,
   parameter int unsigned bs                    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   esm_issue_buffer_if.slave     bus,
   output logic                  alloc_en,
   output logic [$clog2(bs)-1:0] buffer_index,
   output logic [0:bs-1]         valid_entries,
   input  logic [0:bs-1]         independent_instr,
   output logic [$clog2(bs):0]   count,
   output logic                  empty
);
   localparam int unsigned Iw = $clog2(bs);
   typedef logic [Iw-1:0] idx_t;

   logic [Instruction_word_size-1:0] mem [bs];

   logic [0:bs-1]                    valid_q, valid_d;
   logic [0:bs-1]                    settled_q, settled_d;
   logic [0:bs-1]                    pending_q, pending_d;
   logic [0:bs-1]                    elig;
   idx_t                             ptr_q, ptr_d;
   idx_t                             sel;
   idx_t                             out_slot_q, out_slot_d;
   logic                             out_valid_q, out_valid_d;
   logic [Instruction_word_size-1:0] out_instr_q, out_instr_d;
   logic [Iw:0]                      count_q, count_d;
   logic                             any_elig, load, retire, in_ready;

   always_comb begin
      buffer_index = '0;
      for (int i = int'(bs) - 1; i >= 0; i--) begin
         if (!valid_q[i]) buffer_index = idx_t'(i);
      end
   end

   assign in_ready = ~&valid_q;
   assign alloc_en = bus.in_valid & in_ready;

   // Independent bits are trusted only once the core's index synchroniser has seen the slot.
   assign elig = valid_q & settled_q & independent_instr & ~pending_q;

   always_comb begin
      idx_t cand;
      cand     = '0;
      sel      = '0;
      any_elig = 1'b0;
      for (int k = 0; k < int'(bs); k++) begin
         cand = ptr_q + idx_t'(k);
         if (!any_elig && elig[cand]) begin
            sel      = cand;
            any_elig = 1'b1;
         end
      end
   end

   assign retire = out_valid_q & bus.out_ready;
   assign load   = (~out_valid_q | bus.out_ready) & any_elig;

   always_comb begin
      valid_d     = valid_q;
      settled_d   = settled_q | valid_q;
      pending_d   = pending_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_slot_d  = out_slot_q;
      ptr_d       = ptr_q;
      // The retiring slot is pending, so it can never be the allocation or selection target.
      if (retire) begin
         valid_d[out_slot_q]   = 1'b0;
         settled_d[out_slot_q] = 1'b0;
         pending_d[out_slot_q] = 1'b0;
      end
      if (alloc_en) valid_d[buffer_index] = 1'b1;
      if (load) begin
         pending_d[sel] = 1'b1;
         out_valid_d    = 1'b1;
         out_instr_d    = mem[sel];
         out_slot_d     = sel;
         ptr_d          = sel + idx_t'(1);
      end else if (retire) begin
         out_valid_d = 1'b0;
      end
      count_d = count_q + {{Iw{1'b0}}, alloc_en} - {{Iw{1'b0}}, retire};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         settled_q   <= '0;
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_slot_q  <= '0;
         ptr_q       <= '0;
         count_q     <= '0;
      end else begin
         valid_q     <= valid_d;
         settled_q   <= settled_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_slot_q  <= out_slot_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_en) mem[buffer_index] <= bus.Instr_in;
   end

   assign valid_entries = valid_q;
   assign count         = count_q;
   assign empty         = (count_q == '0);
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_slot  = out_slot_q;
endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed bench for esm_issue_buffer; issued instructions are checked against a scoreboard queue.
module tb_esm_issue_buffer;
   typedef struct packed {
      logic [3:0]  slot;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_en;
   logic [3:0]  buffer_index;
   logic [0:15] valid_entries;
   logic [0:15] indep;
   logic [4:0]  count;
   logic        empty;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   int   n;

   esm_issue_buffer_if #(.Instruction_word_size(32), .bs(16)) ifc ();

   esm_issue_buffer #(.Instruction_word_size(32), .bs(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (ifc),
      .alloc_en          (alloc_en),
      .buffer_index      (buffer_index),
      .valid_entries     (valid_entries),
      .independent_instr (indep),
      .count             (count),
      .empty             (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] slot, input logic [31:0] instr);
      exp_t e;
      e.slot  = slot;
      e.instr = instr;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      indep         = '0;
      step();
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic fill16(input logic [31:0] base, input bit do_push);
      for (int i = 0; i < 16; i++) begin
         ifc.in_valid = 1'b1;
         ifc.Instr_in = base + 32'(i);
         #1;
         chk("fill_idx", buffer_index, 64'(i));
         chk("fill_alloc", alloc_en, 1);
         if (do_push) push(4'(i), base + 32'(i));
         step();
      end
      ifc.in_valid = 1'b0;
   endtask

   // Every issue handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && ifc.out_valid && ifc.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow: got slot %0d want no issue", ifc.out_slot);
         end else begin
            mon_e = sb.pop_front();
            chk("iss_slot", ifc.out_slot, mon_e.slot);
            chk("iss_instr", ifc.out_instr, mon_e.instr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.Instr_in  = '0;
      ifc.out_ready = 1'b0;
      indep         = '0;
      step();
      step();
      chk("rst_valid", valid_entries, 0);
      chk("rst_oval", ifc.out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_inrdy", ifc.in_ready, 1);
      chk("rst_idx", buffer_index, 0);
      chk("rst_oinstr", ifc.out_instr, 0);
      chk("rst_oslot", ifc.out_slot, 0);
      rst = 1'b0;

      // Single instruction: latency and free-after-issue
      ifc.in_valid  = 1'b1;
      ifc.Instr_in  = 32'h00A00093;
      indep         = 16'h8000;
      ifc.out_ready = 1'b1;
      #1;
      chk("t1_alloc", alloc_en, 1);
      chk("t1_idx", buffer_index, 0);
      push(4'd0, 32'h00A00093);
      step();
      ifc.in_valid = 1'b0;
      chk("t1_valid", valid_entries, 16'h8000);
      chk("t1_oval_t1", ifc.out_valid, 0);
      step();
      chk("t1_oval_t2", ifc.out_valid, 0);
      step();
      chk("t1_oval_t3", ifc.out_valid, 1);
      chk("t1_oslot", ifc.out_slot, 0);
      chk("t1_oinstr", ifc.out_instr, 32'h00A00093);
      step();
      chk("t1_oval_after", ifc.out_valid, 0);
      chk("t1_empty", empty, 1);
      chk("t1_valid_after", valid_entries, 0);

      // Fill with backpressure, then a 17th offer
      do_reset();
      fill16(32'h1000_0000, 1'b1);
      ifc.in_valid = 1'b1;
      ifc.Instr_in = 32'hDEAD_BEEF;
      #1;
      chk("full_count", count, 16);
      chk("full_inrdy", ifc.in_ready, 0);
      chk("full_alloc", alloc_en, 0);
      step();
      ifc.in_valid = 1'b0;
      chk("full_count2", count, 16);

      // Drain at full rate in slot order
      indep         = 16'hFFFF;
      ifc.out_ready = 1'b1;
      step();
      for (int k = 0; k < 16; k++) begin
         chk("drain_oval", ifc.out_valid, 1);
         chk("drain_slot", ifc.out_slot, 64'(k));
         chk("drain_count", count, 64'(16 - k));
         step();
      end
      chk("drain_oval_end", ifc.out_valid, 0);
      chk("drain_empty", empty, 1);

      // Slot 3 not independent: order 0,1,2,4 then 3
      ifc.out_ready = 1'b0;
      indep         = '0;
      ifc.in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ifc.Instr_in = 32'h4000_0000 + 32'(i);
         step();
      end
      ifc.in_valid = 1'b0;
      push(4'd0, 32'h4000_0000);
      push(4'd1, 32'h4000_0001);
      push(4'd2, 32'h4000_0002);
      push(4'd4, 32'h4000_0004);
      push(4'd3, 32'h4000_0003);
      step();
      step();
      indep         = 16'b1110_1000_0000_0000;
      ifc.out_ready = 1'b1;
      repeat (7) step();
      chk("rr_valid", valid_entries, 16'b0001_0000_0000_0000);
      chk("rr_count", count, 1);
      chk("rr_oval", ifc.out_valid, 0);
      indep = 16'hFFFF;
      repeat (4) step();
      chk("rr_empty", empty, 1);
      chk("rr_sb_drained", sb.size(), 0);

      // Backpressure holds the issue stage
      ifc.out_ready = 1'b0;
      ifc.in_valid  = 1'b1;
      ifc.Instr_in  = 32'h5A5A_0001;
      push(4'd0, 32'h5A5A_0001);
      step();
      ifc.Instr_in = 32'h5A5A_0002;
      push(4'd1, 32'h5A5A_0002);
      step();
      ifc.in_valid = 1'b0;
      n = 0;
      while (!ifc.out_valid && n < 10) begin
         step();
         n++;
      end
      chk("bp_wait", ifc.out_valid, 1);
      repeat (5) begin
         chk("bp_slot", ifc.out_slot, 0);
         chk("bp_instr", ifc.out_instr, 32'h5A5A_0001);
         chk("bp_count", count, 2);
         chk("bp_held", valid_entries[0], 1);
         step();
      end
      ifc.out_ready = 1'b1;
      repeat (4) step();
      chk("bp_empty", empty, 1);
      chk("bp_oval", ifc.out_valid, 0);
      chk("bp_sb_drained", sb.size(), 0);

      // Full buffer, retire slot 7 with in_valid held
      do_reset();
      fill16(32'h6000_0000, 1'b0);
      push(4'd7, 32'h6000_0007);
      indep        = 16'h0100;
      ifc.in_valid = 1'b1;
      ifc.Instr_in = 32'hC0FF_EE07;
      step();
      chk("f7_oval", ifc.out_valid, 1);
      chk("f7_oslot", ifc.out_slot, 7);
      chk("f7_inrdy_full", ifc.in_ready, 0);
      chk("f7_alloc_full", alloc_en, 0);
      ifc.out_ready = 1'b1;
      step();
      ifc.out_ready = 1'b0;
      #1;
      chk("f7_inrdy", ifc.in_ready, 1);
      chk("f7_idx", buffer_index, 7);
      chk("f7_alloc", alloc_en, 1);
      chk("f7_count", count, 15);
      push(4'd7, 32'hC0FF_EE07);
      step();
      ifc.in_valid = 1'b0;
      chk("f7_refull", valid_entries, 16'hFFFF);
      chk("f7_count16", count, 16);
      chk("f7_unsettled1", ifc.out_valid, 0);
      step();
      chk("f7_unsettled2", ifc.out_valid, 0);
      step();
      chk("f7_reissue", ifc.out_valid, 1);
      chk("f7_reslot", ifc.out_slot, 7);
      chk("f7_reinstr", ifc.out_instr, 32'hC0FF_EE07);

      // Asynchronous reset mid-stream
      #2;
      rst = 1'b1;
      #1;
      chk("mid_oval", ifc.out_valid, 0);
      chk("mid_valid", valid_entries, 0);
      chk("mid_count", count, 0);
      chk("mid_empty", empty, 1);
      chk("mid_oinstr", ifc.out_instr, 0);
      chk("mid_oslot", ifc.out_slot, 0);
      chk("mid_inrdy", ifc.in_ready, 1);
      sb.delete();
      step();
      rst = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/esm_issue_buffer.md
Name: esm_issue_buffer

Overview:
- Instruction buffer plus allocate/issue controller on the consumer side of the ESM dependency-analysis core.
- Allocates a free slot for each incoming instruction and drives `buffer_index` and `valid_entries` into the core.
- Consumes the core's `independent_instr` vector and issues one ready instruction per cycle through a valid/ready output stage.
- Frees the slot on issue handshake.

Parameters:
- Instruction_word_size, 32, instruction width in bits
- bs, 16, buffer depth (power of 2, ≥2); slot index width = $clog2(bs)

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream offers Instr_in
- in_ready  output  1  buffer can accept (not full)
- Instr_in  input  Instruction_word_size  incoming instruction
- alloc_en  output  1  pulse: Instr_in written to slot buffer_index this cycle
- buffer_index  output  $clog2(bs)  lowest-numbered free slot (allocation target)
- valid_entries  output  [0:bs-1]  registered occupancy vector; bit i = slot i holds an instruction
- independent_instr  input  [0:bs-1]  from dependency core; bit i = slot i has no outstanding producer
- out_valid  output  1  issue stage holds an instruction
- out_ready  input  1  downstream accepts
- out_instr  output  Instruction_word_size  issued instruction
- out_slot  output  $clog2(bs)  slot of issued instruction
- count  output  $clog2(bs)+1  number of occupied slots
- empty  output  1  count==0

Behaviour:
- Reset (async, immediate): `valid_entries`=0, settled=0, pending=0, `out_valid`=0, `out_instr`=0, `out_slot`=0, `count`=0, `empty`=1, round-robin pointer=0. The memory array is not reset.
- Combinational outputs:
  - `in_ready` = ~&valid_entries.
  - `buffer_index` = lowest i with valid_entries[i]==0; value 0 when full, with `in_ready`=0.
  - `alloc_en` = in_valid & in_ready.
- Allocation: on `alloc_en` at edge T:
  - mem[buffer_index] <= Instr_in.
  - valid_entries[buffer_index] <= 1 (visible T+1).
  - settled[buffer_index] set one cycle later (visible T+2).
  - Settling covers the core's one-cycle index synchroniser: a slot's independent bit is trusted only when settled=1.
- Eligibility: elig[i] = valid_entries[i] & settled[i] & independent_instr[i] & ~pending[i].
- Selection: round-robin among elig, starting at pointer; the first eligible index at or above the pointer wins, wrapping modulo bs.
- Issue stage (single register):
  - Load when stage is empty or (out_valid & out_ready), and any elig is set.
  - On load: out_instr <= mem[sel], out_slot <= sel, out_valid <= 1, pending[sel] <= 1, pointer <= sel+1 mod bs.
  - If no elig and the handshake occurs: out_valid <= 0.
  - out_instr and out_slot hold stable while out_valid & ~out_ready.
- Retire: on out_valid & out_ready at edge, clear valid_entries[out_slot], settled[out_slot] and pending[out_slot].
  - The slot is allocatable from the next cycle; it is never reallocated in the same cycle it is freed.
  - Allocation decisions use registered valid_entries only.
- Simultaneous events:
  - Alloc, retire and new issue load in the same cycle are all permitted and act on distinct slots.
  - `count` = count + alloc_en − retire, which may net to 0.
- Issue latency: accepted at edge T → earliest out_valid at T+3 (selected during T+2, registered at its end), given independent_instr set. Sustained throughput is 1 issue per cycle.
- Full: in_ready=0, in_valid is ignored, and no memory write occurs.
- Empty: empty=1 and out_valid stays 0.
- independent_instr bits for invalid or unsettled slots are ignored.
- Reset mid-operation: everything clears immediately, and an in-flight out_valid drops without handshake.

Test Plan:
- Reset then single write of 0x00A00093 → alloc_en=1 with buffer_index=0; valid_entries=1000…0 next cycle; with independent_instr[0]=1 and out_ready=1, out_valid=1 at T+3 with out_instr=0x00A00093 and out_slot=0; slot 0 freed the following cycle, empty=1.
- Fill 16 back-to-back with out_ready=0 → buffer_index 0..15 in order, count=16, in_ready=0; a 17th in_valid causes no write and no count change.
- With all slots settled and independent_instr=all ones, out_ready=1 continuously → out_slot issues 0,1,2,…,15 in consecutive cycles, count decrements by 1 per cycle to 0.
- independent_instr[3]=0 while slots 2 and 4 are eligible, pointer=2 → issues 2 then 4; slot 3 stays valid until bit 3 rises, then issues.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles → out_instr and out_slot stable, slot not freed, and the same slot is not reselected.
- Full buffer, retire slot 7 while in_valid=1 → in_ready rises next cycle, buffer_index=7, and the write lands in slot 7; assert rst mid-stream → outputs return to reset values immediately.
